// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage                                                                |
// | PC register with BHT/BTB next-PC prediction (built when FETCH_BPRED_EN is  |
// | defined; otherwise fetch is purely sequential). Reset rst is async, low.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter int XLEN        = 32,
  parameter int PC_BITS     = 5,
  parameter int BP_IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken,
  input  logic               stall_D,
  input  logic               MEM_stall,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_redirect_pc,
  input  logic               EX_br_valid,
  input  logic [PC_BITS-1:0] EX_br_pc,
  input  logic               EX_br_taken,
  input  logic [PC_BITS-1:0] EX_br_target
);

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] w_pc_inc;
  logic [PC_BITS-1:0] w_pred_pc;
  logic               w_pred_taken;

  // Natural width wrap gives the modulo-2^PC_BITS increment.
  assign w_pc_inc = r_pc + {{(PC_BITS-1){1'b0}}, 1'b1};

`ifdef FETCH_BPRED_EN
  localparam int c_ENTRIES = 1 << BP_IDX_BITS;

  logic [1:0]             r_bht       [c_ENTRIES];
  logic [c_ENTRIES-1:0]   r_btb_valid;
  logic [PC_BITS-1:0]     r_btb_tgt   [c_ENTRIES];
  logic [BP_IDX_BITS-1:0] w_fi;
  logic [BP_IDX_BITS-1:0] w_ui;
  logic                   w_train;
  logic                   w_unused_br_pc;

  assign w_fi           = r_pc[BP_IDX_BITS-1:0];
  assign w_ui           = EX_br_pc[BP_IDX_BITS-1:0];
  assign w_train        = EX_br_valid & ~MEM_stall;
  assign w_unused_br_pc = ^EX_br_pc;

  assign w_pred_taken = r_bht[w_fi][1] & r_btb_valid[w_fi];
  assign w_pred_pc    = w_pred_taken ? r_btb_tgt[w_fi] : w_pc_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
      r_btb_valid <= '0;
    end else if (w_train) begin
      if (EX_br_taken) begin
        if (r_bht[w_ui] != 2'b11) begin
          r_bht[w_ui] <= r_bht[w_ui] + 2'b01;
        end
        r_btb_valid[w_ui] <= 1'b1;
      end else if (r_bht[w_ui] != 2'b00) begin
        r_bht[w_ui] <= r_bht[w_ui] - 2'b01;
      end
    end
  end

  // Targets need no reset: a stale target is masked by its valid bit.
  always_ff @(posedge clk) begin
    if (w_train && EX_br_taken) begin
      r_btb_tgt[w_ui] <= EX_br_target;
    end
  end
`else
  logic w_unused_br;

  assign w_unused_br  = ^{EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target};
  assign w_pred_taken = 1'b0;
  assign w_pred_pc    = w_pc_inc;
`endif

  // Redirect outranks both stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (EX_taken) begin
      r_pc <= EX_redirect_pc;
    end else if (!(stall_D || MEM_stall)) begin
      r_pc <= w_pred_pc;
    end
  end

  assign imem_addr  = r_pc;
  assign F_pc       = r_pc;
  assign F_inst     = imem_rdata;
  assign F_BP_taken = w_pred_taken;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage                                                             |
// | Directed stimulus with an in-bench predictor model and literal checks.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam int c_NPC = 32;
  localparam int c_NE  = 16;
`ifdef FETCH_BPRED_EN
  localparam bit c_BPRED = 1'b1;
`else
  localparam bit c_BPRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  F_pc;
  logic [31:0] F_inst;
  logic        F_BP_taken;
  logic        stall_D = 1'b0, MEM_stall = 1'b0, EX_taken = 1'b0;
  logic [4:0]  EX_redirect_pc = '0;
  logic        EX_br_valid = 1'b0, EX_br_taken = 1'b0;
  logic [4:0]  EX_br_pc = '0, EX_br_target = '0;

  fetch_stage #(.XLEN(32), .PC_BITS(5), .BP_IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .F_pc(F_pc), .F_inst(F_inst), .F_BP_taken(F_BP_taken),
    .stall_D(stall_D), .MEM_stall(MEM_stall), .EX_taken(EX_taken),
    .EX_redirect_pc(EX_redirect_pc), .EX_br_valid(EX_br_valid), .EX_br_pc(EX_br_pc),
    .EX_br_taken(EX_br_taken), .EX_br_target(EX_br_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int a);
    return 32'h1000_0000 | (a * 32'h0000_0101);
  endfunction

  assign imem_rdata = mem_word(int'(imem_addr));

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer, counters as 0..3 integers.
  int m_pc;
  int m_bht [c_NE];
  bit m_val [c_NE];
  int m_tgt [c_NE];

  function automatic bit m_pred();
    return c_BPRED && (m_bht[m_pc % c_NE] >= 2) && m_val[m_pc % c_NE];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 0;
      for (int i = 0; i < c_NE; i++) begin
        m_bht[i] = 1;
        m_val[i] = 1'b0;
        m_tgt[i] = 0;
      end
    end else begin
      int nxt;
      int ui;
      nxt = m_pred() ? m_tgt[m_pc % c_NE] : (m_pc + 1) % c_NPC;
      if (EX_taken) nxt = int'(EX_redirect_pc);
      else if (stall_D || MEM_stall) nxt = m_pc;
      if (c_BPRED && EX_br_valid && !MEM_stall) begin
        ui = int'(EX_br_pc) % c_NE;
        if (EX_br_taken) begin
          m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
          m_val[ui] = 1'b1;
          m_tgt[ui] = int'(EX_br_target);
        end else begin
          m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
        end
      end
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("F_pc", {27'd0, F_pc}, m_pc);
      chk("imem_addr", {27'd0, imem_addr}, m_pc);
      chk("F_inst", F_inst, mem_word(m_pc));
      chk("F_BP_taken", {31'd0, F_BP_taken}, {31'd0, m_pred()});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [4:0] p);
    EX_taken = 1'b1;
    EX_redirect_pc = p;
    step(1);
    EX_taken = 1'b0;
  endtask

  task automatic train(input logic [4:0] p, input logic tk, input logic [4:0] tgt, input int n);
    EX_br_valid = 1'b1;
    EX_br_pc = p;
    EX_br_taken = tk;
    EX_br_target = tgt;
    step(n);
    EX_br_valid = 1'b0;
  endtask

  initial begin
    step(2);
    chk("reset F_pc", {27'd0, F_pc}, 0);
    chk("reset F_BP_taken", {31'd0, F_BP_taken}, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq after reset", {27'd0, F_pc}, i);
      step(1);
    end
    step(3);
    chk("at 7", {27'd0, F_pc}, 7);
    #3 rst = 1'b0;
    #1;
    chk("async reset F_pc", {27'd0, F_pc}, 0);
    chk("async reset F_BP_taken", {31'd0, F_BP_taken}, 0);
    step(1);
    rst = 1'b1;
    step(31);
    chk("pc 31", {27'd0, F_pc}, 31);
    step(1);
    chk("wrap to 0", {27'd0, F_pc}, 0);

    // Stalls at pc 4 and then at pc 5.
    step(4);
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_D hold", {27'd0, F_pc}, 4);
    end
    stall_D = 1'b0;
    step(1);
    chk("after stall_D", {27'd0, F_pc}, 5);
    MEM_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("MEM_stall hold", {27'd0, F_pc}, 5);
    end
    MEM_stall = 1'b0;
    step(1);
    chk("after MEM_stall", {27'd0, F_pc}, 6);

    stall_D = 1'b1;
    MEM_stall = 1'b1;
    redirect(5'd20);
    stall_D = 1'b0;
    MEM_stall = 1'b0;
    chk("redirect beats stall", {27'd0, F_pc}, 20);

`ifdef FETCH_BPRED_EN
    train(5'd3, 1'b1, 5'd12, 2);
    redirect(5'd3);
    chk("trained taken", {31'd0, F_BP_taken}, 1);
    step(1);
    chk("btb target", {27'd0, F_pc}, 12);
    train(5'd3, 1'b0, 5'd0, 2);
    redirect(5'd3);
    chk("untrained", {31'd0, F_BP_taken}, 0);
    step(1);
    chk("sequential after untrain", {27'd0, F_pc}, 4);
    train(5'd3, 1'b1, 5'd12, 4);
    train(5'd3, 1'b0, 5'd0, 1);
    redirect(5'd3);
    chk("saturated stays taken", {31'd0, F_BP_taken}, 1);

    // Counter is 2: five stalled not-taken updates must count as one.
    MEM_stall = 1'b1;
    EX_br_valid = 1'b1;
    EX_br_pc = 5'd3;
    EX_br_taken = 1'b0;
    step(5);
    MEM_stall = 1'b0;
    step(1);
    EX_br_valid = 1'b0;
    train(5'd3, 1'b1, 5'd12, 1);
    redirect(5'd3);
    chk("MEM_stall blocks training", {31'd0, F_BP_taken}, 1);

    train(5'd3, 1'b0, 5'd0, 1);
    redirect(5'd3);
    chk("weak before same-cycle", {31'd0, F_BP_taken}, 0);
    EX_br_valid = 1'b1;
    EX_br_pc = 5'd3;
    EX_br_taken = 1'b1;
    EX_br_target = 5'd12;
    #0;
    chk("same-cycle sees old", {31'd0, F_BP_taken}, 0);
    step(1);
    EX_br_valid = 1'b0;
    chk("same-cycle next pc", {27'd0, F_pc}, 4);
    redirect(5'd3);
    chk("new value visible", {31'd0, F_BP_taken}, 1);
`else
    redirect(5'd3);
    EX_br_valid = 1'b1;
    EX_br_pc = 5'd3;
    EX_br_taken = 1'b1;
    EX_br_target = 5'd12;
    for (int i = 0; i < 4; i++) begin
      chk("no bpred taken", {31'd0, F_BP_taken}, 0);
      step(1);
      chk("no bpred sequential", {27'd0, F_pc}, 4 + i);
    end
    EX_br_valid = 1'b0;
    redirect(5'd3);
    chk("no bpred at 3", {31'd0, F_BP_taken}, 0);
`endif

    step(3);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: holds the program counter, addresses instruction memory, and predicts the next PC with a direct-mapped 2-bit branch history table (BHT) plus a branch target buffer (BTB). Its outputs `F_pc`, `F_inst` and `F_BP_taken` feed the fetch-to-decode pipeline register directly. It honours the decode and memory stall signals and accepts redirects and predictor training from the execute stage.

## Interface
- `XLEN`, 32, instruction width
- `PC_BITS`, 5, PC width; PC is a word index, so +1 is the next instruction
- `BP_IDX_BITS`, 4, log2 of BHT/BTB entries; must be ≤ `PC_BITS`

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `imem_addr`  out  PC_BITS  instruction memory address, equals current PC
- `imem_rdata`  in  XLEN  instruction memory read data, combinational from `imem_addr`
- `F_pc`  out  PC_BITS  PC of the instruction being fetched
- `F_inst`  out  XLEN  fetched instruction, equals `imem_rdata`
- `F_BP_taken`  out  1  1 = fetched instruction predicted taken
- `stall_D`  in  1  decode stall; hold PC
- `MEM_stall`  in  1  memory stall; hold PC, suppress predictor training
- `EX_taken`  in  1  execute redirect: misprediction detected, PC must become `EX_redirect_pc`
- `EX_redirect_pc`  in  PC_BITS  correct next PC on redirect
- `EX_br_valid`  in  1  execute stage resolves a branch this cycle
- `EX_br_pc`  in  PC_BITS  PC of the resolved branch
- `EX_br_taken`  in  1  actual outcome of the resolved branch
- `EX_br_target`  in  PC_BITS  actual target of the resolved branch

## Operation
- State: `pc` register; `bht[2^BP_IDX_BITS]` 2-bit counters; `btb_valid[...]` 1 bit; `btb_tgt[...]` PC_BITS.
- Lookup index `fi = pc[BP_IDX_BITS-1:0]`. The lookup is combinational from the current `pc`.
- Prediction: `F_BP_taken = bht[fi][1] & btb_valid[fi]`. The predicted next PC is `btb_tgt[fi]` if taken, else `pc + 1`, computed modulo 2^PC_BITS (wraps max → 0).
- Next-PC priority, highest first:
  - `EX_taken`: `pc <= EX_redirect_pc`, even when stalled.
  - `stall_D | MEM_stall`: hold `pc`.
  - Otherwise: `pc <=` predicted next PC.
- Training happens when `EX_br_valid & !MEM_stall`, with index `ui = EX_br_pc[BP_IDX_BITS-1:0]`:
  - `bht[ui]` saturating increment if `EX_br_taken`, else saturating decrement. The counter runs 0..3, so 3 stays 3 and 0 stays 0.
  - If `EX_br_taken`: `btb_tgt[ui] <= EX_br_target` and `btb_valid[ui] <= 1`. Not-taken leaves the BTB unchanged.
- Training is independent of `stall_D` and `EX_taken`.
- Index aliasing is permitted; there are no tags.

## Timing
- Reset is asserted asynchronously, and all state clears immediately:
  - `pc` = 0
  - every `bht` = 2'b01 (weakly not-taken)
  - every `btb_valid` = 0
- Resulting outputs during reset: `imem_addr` = `F_pc` = 0 and `F_BP_taken` = 0. `F_inst` follows `imem_rdata`.
- Reset mid-operation discards the current PC and all predictor state.
- First fetch after reset release is at PC 0.
- A redirect asserted in cycle N makes `F_pc` = `EX_redirect_pc` in cycle N+1.
- Same-cycle training and lookup on the same index: the lookup sees the old entry; the new value is visible the next cycle.
- With both stalls low and no redirect, `F_pc` advances every cycle. Fetch latency is zero: outputs are valid in the same cycle as `pc`.

## Configuration
- `FETCH_BPRED_EN` defined: the BHT/BTB are built, and prediction and training behave as described above.
- `FETCH_BPRED_EN` undefined:
  - No BHT/BTB storage is instantiated.
  - `F_BP_taken` is tied to 0 and the next PC is always `pc + 1`.
  - `EX_br_*` inputs are ignored.
  - Redirect, stall and reset behaviour is unchanged.

## Test plan
- Reset with `rst`=0 mid-run at `pc`=7 → `F_pc`=0 and `F_BP_taken`=0 immediately. After release with no stalls, `F_pc` reads 0, 1, 2, 3; advancing from 31 gives 0 (wrap).
- `stall_D`=1 for 3 cycles at `pc`=4 → `F_pc` stays 4 for those cycles, then continues at 5. Repeat with `MEM_stall`.
- Stall active and `EX_taken`=1, `EX_redirect_pc`=20 in the same cycle → `F_pc`=20 next cycle (redirect wins).
- Training (with `FETCH_BPRED_EN`): two `EX_br_valid` updates with `EX_br_pc`=3, `EX_br_taken`=1, `EX_br_target`=12 → the next fetch at PC 3 gives `F_BP_taken`=1 and the following `F_pc`=12. Two not-taken updates then restore `F_BP_taken`=0. Four taken updates followed by one not-taken keep the prediction taken (saturation at 3).
- `EX_br_valid`=1 with `MEM_stall`=1 for 5 cycles → the BHT changes by nothing. The counter for index 3 moves only once, when the stall drops.
- Same-cycle training and fetch at index 3, with a counter at 01 trained taken → this cycle `F_BP_taken`=0 and the next fetch of PC 3 sees the new value. Build without `FETCH_BPRED_EN` → `F_BP_taken` is always 0 and the PC is always sequential.
